// File: rtl/pbus_xconn.sv
// pbus_xconn: one peripheral-bus master fanned out to SLV_CNT slaves.
// Ports: clk, rstn (async, active low); master side m_req, m_addr,
//   m_w_rb, m_acc, m_wdata -> m_resp, m_rdata; slave side s_req,
//   s_addr, s_w_rb, s_acc, s_wdata -> s_resp, s_rdata (packed, slot
//   i = slave i); bus_fault, bus_fault_tmo, bus_fault_addr to the
//   trap logic; bus_halt forces completions to retire silently;
//   busy = a transaction is outstanding.
// Optional: define PBUS_XCONN_TMO_EN to abort a WAIT after
//   TMO_CYCLES cycles with a timeout fault.
module pbus_xconn #(
  parameter int XLEN        = 32,
  parameter int BUS_WIDTH   = 32,
  parameter int BUS_ACC_CNT = 4,
  parameter int SLV_CNT     = 5,
  parameter logic [SLV_CNT*XLEN-1:0] SLV_BASE = {
    32'h0000_0000,
    32'h0000_4000,
    32'h0000_3000,
    32'h0000_2000,
    32'h0000_1000
  },
  parameter logic [SLV_CNT*8-1:0] SLV_SPAN = {
    8'd16, 8'd8, 8'd8, 8'd8, 8'd8
  },
  parameter int TMO_CYCLES  = 255,
  parameter int TMO_W       = 8,
  localparam int ACC_W      = $clog2(BUS_ACC_CNT)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   m_req,
  input  logic [XLEN-1:0]        m_addr,
  input  logic                   m_w_rb,
  input  logic [ACC_W-1:0]       m_acc,
  input  logic [BUS_WIDTH-1:0]   m_wdata,
  output logic                   m_resp,
  output logic [BUS_WIDTH-1:0]   m_rdata,
  output logic [SLV_CNT-1:0]     s_req,
  output logic [XLEN-1:0]        s_addr,
  output logic                   s_w_rb,
  output logic [ACC_W-1:0]       s_acc,
  output logic [BUS_WIDTH-1:0]   s_wdata,
  input  logic [SLV_CNT-1:0]     s_resp,
  input  logic [SLV_CNT*BUS_WIDTH-1:0] s_rdata,
  output logic                   bus_fault,
  output logic                   bus_fault_tmo,
  output logic [XLEN-1:0]        bus_fault_addr,
  input  logic                   bus_halt,
  output logic                   busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SLV_CNT-1:0]   hit;
  logic [SLV_CNT-1:0]   sel;
  logic [SLV_CNT-1:0]   sel_q;
  logic [SLV_CNT-1:0]   cur_sel;
  logic [XLEN-1:0]      mask;
  logic [BUS_WIDTH-1:0] rdata_mux;
  logic [BUS_WIDTH-1:0] rdata_q;
  logic                 cap;
  logic                 done;
  logic                 unmapped;
  logic                 tmo_abort;

  assign s_addr  = m_addr;
  assign s_w_rb  = m_w_rb;
  assign s_acc   = m_acc;
  assign s_wdata = m_wdata;

  always_comb begin
    hit  = '0;
    mask = '0;
    for (int i = 0; i < SLV_CNT; i++) begin
      mask = (XLEN'(1) << SLV_SPAN[i*8 +: 8])
           - XLEN'(1);
      hit[i] = ((m_addr & ~mask)
             == SLV_BASE[i*XLEN +: XLEN]);
    end
  end

  // isolate lowest set bit: lowest index wins
  assign sel = hit & (~hit + SLV_CNT'(1));

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < SLV_CNT; i++) begin
      rdata_mux = rdata_mux
        | ({BUS_WIDTH{cur_sel[i]}}
        & s_rdata[i*BUS_WIDTH +: BUS_WIDTH]);
    end
  end

`ifdef PBUS_XCONN_TMO_EN
  logic [TMO_W-1:0] cnt;
  logic [XLEN-1:0]  addr_q;
  logic             tmo_hit;

  assign tmo_hit = (cnt == TMO_W'(TMO_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      cnt <= (state_q == WAIT) ? cnt + TMO_W'(1) : '0;
      if (cap) addr_q <= m_addr;
    end
  end

  assign bus_fault_addr = tmo_abort ? addr_q : m_addr;
`else
  logic tmo_hit;
  logic unused_tmo;

  assign tmo_hit        = 1'b0;
  assign unused_tmo     = (TMO_CYCLES > TMO_W);
  assign bus_fault_addr = m_addr;
`endif

  always_comb begin
    state_d   = state_q;
    s_req     = '0;
    cap       = 1'b0;
    done      = 1'b0;
    unmapped  = 1'b0;
    tmo_abort = 1'b0;
    cur_sel   = sel_q;
    unique case (state_q)
      IDLE: begin
        cur_sel = sel;
        if (m_req && !bus_halt) begin
          if (|hit) begin
            s_req = sel;
            cap   = 1'b1;
            if (|(s_resp & sel)) done = 1'b1;
            else state_d = WAIT;
          end else begin
            unmapped = 1'b1;
          end
        end
      end
      WAIT: begin
        if (|(s_resp & sel_q)) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_resp        = done & ~bus_halt;
  assign m_rdata       = m_resp ? rdata_mux : rdata_q;
  assign bus_fault     = unmapped | tmo_abort;
  assign bus_fault_tmo = tmo_abort;
  assign busy          = (state_q == WAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (cap) sel_q <= sel;
      if (m_resp) rdata_q <= rdata_mux;
    end
  end

endmodule

// File: tb/tb_pbus_xconn.sv
// tb_pbus_xconn: randomized transactions against an address-range
//   reference model of the peripheral-bus connector.
module tb_pbus_xconn;

  localparam int N  = 5;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          m_req;
  logic [31:0]   m_addr;
  logic          m_w_rb;
  logic [1:0]    m_acc;
  logic [BW-1:0] m_wdata;
  logic          m_resp;
  logic [BW-1:0] m_rdata;
  logic [N-1:0]  s_req;
  logic [31:0]   s_addr;
  logic          s_w_rb;
  logic [1:0]    s_acc;
  logic [BW-1:0] s_wdata;
  logic [N-1:0]  s_resp;
  logic [N*BW-1:0] s_rdata;
  logic          bus_fault;
  logic          bus_fault_tmo;
  logic [31:0]   bus_fault_addr;
  logic          bus_halt;
  logic          busy;

  always #5 clk = ~clk;

  pbus_xconn #(.TMO_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn),
    .m_req(m_req), .m_addr(m_addr),
    .m_w_rb(m_w_rb), .m_acc(m_acc),
    .m_wdata(m_wdata), .m_resp(m_resp),
    .m_rdata(m_rdata), .s_req(s_req),
    .s_addr(s_addr), .s_w_rb(s_w_rb),
    .s_acc(s_acc), .s_wdata(s_wdata),
    .s_resp(s_resp), .s_rdata(s_rdata),
    .bus_fault(bus_fault),
    .bus_fault_tmo(bus_fault_tmo),
    .bus_fault_addr(bus_fault_addr),
    .bus_halt(bus_halt), .busy(busy)
  );

  int n_run  = 0;
  int n_fail = 0;
  logic [BW-1:0] ref_rd = '0;

  // slot order: EIC, UART, GPIO, TMR, RST
  int unsigned base_t[N] = '{32'h1000, 32'h2000,
                             32'h3000, 32'h4000, 32'h0};
  int unsigned size_t[N] = '{256, 256, 256, 256, 65536};

  function automatic int ref_dec(logic [31:0] a);
    for (int i = 0; i < N; i++) begin
      if (longint'(a) >= longint'(base_t[i]) &&
          longint'(a) < longint'(base_t[i])
                      + longint'(size_t[i]))
        return i;
    end
    return -1;
  endfunction

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic fill_rdata(int e, logic [BW-1:0] rd);
    for (int i = 0; i < N; i++)
      s_rdata[i*BW +: BW] = (i == e) ? rd : BW'($urandom);
  endtask

  task automatic go_idle();
    @(negedge clk);
    m_req = 1'b0; s_resp = '0; bus_halt = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_resp", m_resp, 0);
    chk("idle_rdata", m_rdata, ref_rd);
  endtask

  task automatic txn(input logic [31:0] a, input int lat,
                     input bit halt, input bit stray,
                     input logic [BW-1:0] rd);
    int e;
    bit drop;
    logic [N-1:0] oh;
    logic [N-1:0] junk;
    e    = ref_dec(a);
    drop = halt && (lat == 0);
    oh   = (e >= 0) ? N'(1 << e) : '0;
    @(negedge clk);
    m_req = 1'b1; m_addr = a; bus_halt = drop;
    m_w_rb = 1'($urandom); m_acc = 2'($urandom);
    m_wdata = $urandom;
    fill_rdata(e, rd);
    s_resp = (lat == 0) ? oh : '0;
    #1;
    chk("bcast_addr", s_addr, a);
    chk("bcast_wdata", s_wdata, m_wdata);
    if (drop) begin
      chk("drop_sreq", s_req, 0);
      chk("drop_fault", bus_fault, 0);
      chk("drop_resp", m_resp, 0);
    end else if (e < 0) begin
      chk("unm_fault", bus_fault, 1);
      chk("unm_tmo", bus_fault_tmo, 0);
      chk("unm_addr", bus_fault_addr, a);
      chk("unm_sreq", s_req, 0);
      chk("unm_resp", m_resp, 0);
      chk("unm_rdata", m_rdata, ref_rd);
    end else begin
      chk("req_sreq", s_req, oh);
      chk("req_fault", bus_fault, 0);
      if (lat == 0) begin
        chk("zl_resp", m_resp, 1);
        chk("zl_rdata", m_rdata, rd);
        ref_rd = rd;
      end else begin
        chk("req_resp", m_resp, 0);
      end
    end
    if (!drop && e >= 0) begin
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        m_req = 1'($urandom);
        m_addr = $urandom;
        bus_halt = (k == lat) && halt;
        fill_rdata(e, rd);
        junk = stray ? (N'($urandom) & ~oh) : '0;
        s_resp = ((k == lat) ? oh : '0) | junk;
        #1;
        chk("w_busy", busy, 1);
        chk("w_sreq", s_req, 0);
        chk("w_fault", bus_fault, 0);
        if (k == lat) begin
          chk("done_resp", m_resp, !halt);
          chk("done_rdata", m_rdata, halt ? ref_rd : rd);
          if (!halt) ref_rd = rd;
        end else begin
          chk("w_resp", m_resp, 0);
          chk("w_rdata", m_rdata, ref_rd);
        end
      end
    end
    go_idle();
  endtask

  initial begin
    logic [31:0] a;
    rstn = 1'b0; m_req = 1'b0; m_addr = '0;
    m_w_rb = 1'b0; m_acc = '0; m_wdata = '0;
    s_resp = '0; s_rdata = '0; bus_halt = 1'b0;
    #12;
    chk("rst_resp", m_resp, 0);
    chk("rst_sreq", s_req, 0);
    chk("rst_fault", bus_fault, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", m_rdata, 0);
    @(negedge clk);
    rstn = 1'b1;

    // UART read, 3-cycle latency
    txn(32'h2004, 3, 0, 0, 32'hA5);
    // zero latency to EIC (also overlaps RST window)
    txn(32'h1000, 0, 0, 0, 32'h1234_5678);
    // unmapped
    txn(32'hDEAD_0000, 2, 0, 0, 32'h0);
    // TMR with stray responses, then halted completion
    txn(32'h4010, 3, 0, 1, 32'h0BAD_F00D);
    txn(32'h4020, 2, 1, 1, 32'h5555_AAAA);
    // request while halted is dropped
    txn(32'h3000, 0, 1, 0, 32'h7777);
    // RST-only region
    txn(32'h8000, 1, 0, 0, 32'hCAFE);

`ifdef PBUS_XCONN_TMO_EN
    @(negedge clk);
    m_req = 1'b1; m_addr = 32'h3008;
    #1;
    chk("tmo_sreq", s_req, 5'b00100);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      m_req = 1'b0; m_addr = '0;
      #1;
      chk("tmo_fault", bus_fault, k == 4);
      chk("tmo_tmo", bus_fault_tmo, k == 4);
      chk("tmo_resp", m_resp, 0);
      if (k == 4) chk("tmo_addr", bus_fault_addr, 32'h3008);
    end
    go_idle();
`else
    @(negedge clk);
    m_req = 1'b1; m_addr = 32'h3008;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      m_req = 1'b0;
      #1;
      chk("notmo_busy", busy, 1);
      chk("notmo_fault", bus_fault, 0);
    end
    @(negedge clk);
    s_resp = 5'b00100; fill_rdata(2, 32'h99);
    #1;
    chk("notmo_resp", m_resp, 1);
    ref_rd = 32'h99;
    go_idle();
`endif

    // reset mid-WAIT
    @(negedge clk);
    m_req = 1'b1; m_addr = 32'h3000;
    @(negedge clk);
    m_req = 1'b0;
    #1;
    chk("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    #1;
    ref_rd = '0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdata", m_rdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    s_resp = 5'b00100;
    #1;
    chk("late_resp", m_resp, 0);
    chk("late_busy", busy, 0);
    go_idle();
    txn(32'h3004, 2, 0, 0, 32'h4242);

    for (int t = 0; t < 60; t++) begin
      int j;
      j = $urandom_range(0, 5);
      if (j < 4) a = base_t[j] + $urandom_range(0, 255);
      else if (j == 4) a = 32'h8000 + $urandom_range(0, 32'h7FFF);
      else a = 32'hDEAD_0000 | ($urandom & 32'hFFFF);
      txn(a, $urandom_range(0, 4),
          ($urandom_range(0, 4) == 0),
          1'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
